// File: rtl/se_conf_loader.sv
// Double-buffered CONF_SE writer: host writes fill a shadow bank; COMMIT swaps it into the active bank once the array is idle.
// Optional build macro SE_CONF_CHECK_EN rejects writes containing undefined switch codes or self-loops.
module se_conf_loader #(
  parameter int NUM_PE = 8,
  parameter int AW     = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 WR_VALID,
  output logic                 WR_READY,
  input  logic [AW-1:0]        WR_ADDR,
  input  logic [15:0]          WR_DATA,
  input  logic                 COMMIT,
  input  logic                 ARRAY_BUSY,
  output logic [NUM_PE*16-1:0] CONF_SE_ALL,
  output logic                 CONF_VALID,
  output logic                 PENDING,
  output logic                 ERR,
  input  logic                 ERR_CLR
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_IDLE = 2'd1;
  localparam logic [1:0] SWAP      = 2'd2;

  // Extra bit so NUM_PE == 2**AW still compares correctly.
  localparam logic [AW:0] PE_LIMIT = (AW+1)'(NUM_PE);

`ifdef SE_CONF_CHECK_EN
  // Switch encodings: 0 none, 1 north, 2 east, 3 south, 4 west, 5 PE, 6 const A, 7 const B.
  localparam logic [3:0] CONF_SW_NORTH   = 4'd1;
  localparam logic [3:0] CONF_SW_EAST    = 4'd2;
  localparam logic [3:0] CONF_SW_SOUTH   = 4'd3;
  localparam logic [3:0] CONF_SW_WEST    = 4'd4;
  localparam logic [3:0] CONF_SW_CONST_B = 4'd7;

  function automatic logic field_ok(input logic [3:0] code, input logic [3:0] self_code);
    return (code <= CONF_SW_CONST_B) && (code != self_code);
  endfunction

  // Word layout is {N,S,E,W}; a port may not route back onto itself.
  function automatic logic word_ok(input logic [15:0] w);
    return field_ok(w[15:12], CONF_SW_NORTH) && field_ok(w[11:8], CONF_SW_SOUTH) &&
           field_ok(w[7:4], CONF_SW_EAST) && field_ok(w[3:0], CONF_SW_WEST);
  endfunction
`endif

  logic [1:0]           state;
  logic [1:0]           next_state;
  logic [NUM_PE*16-1:0] shadow;
  logic                 wr_fire;
  logic                 addr_ok;
  logic                 data_ok;
  logic                 wr_store;
  logic                 wr_err;
  logic                 pending_next;

  always_comb begin
    wr_fire      = WR_VALID && WR_READY;
    addr_ok      = ({1'b0, WR_ADDR} < PE_LIMIT);
`ifdef SE_CONF_CHECK_EN
    data_ok      = word_ok(WR_DATA);
`else
    data_ok      = 1'b1;
`endif
    wr_store     = wr_fire && addr_ok && data_ok;
    wr_err       = wr_fire && !(addr_ok && data_ok);
    pending_next = PENDING || wr_store;
    next_state   = state;
    case (state)
      IDLE: begin
        // A write landing with COMMIT counts as pending for that commit.
        if (COMMIT && pending_next) begin
          next_state = ARRAY_BUSY ? WAIT_IDLE : SWAP;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!ARRAY_BUSY) begin
          next_state = SWAP;
        end else begin
          next_state = WAIT_IDLE;
        end
      end
      SWAP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      WR_READY    <= 1'b1;
      shadow      <= '0;
      CONF_SE_ALL <= '0;
      CONF_VALID  <= 1'b0;
      PENDING     <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      state    <= next_state;
      WR_READY <= (next_state == IDLE);
      for (int i = 0; i < NUM_PE; i++) begin
        if (wr_store && (WR_ADDR == AW'(i))) begin
          shadow[16*i +: 16] <= WR_DATA;
        end
      end
      if (state == SWAP) begin
        CONF_SE_ALL <= shadow;
        CONF_VALID  <= 1'b1;
        PENDING     <= 1'b0;
      end else begin
        PENDING     <= pending_next;
      end
      if (wr_err) begin
        ERR <= 1'b1;
      end else if (ERR_CLR) begin
        ERR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_se_conf_loader.sv
// Scoreboard bench for se_conf_loader: expected banks are queued at COMMIT and compared when the swap lands.
module tb_se_conf_loader;
  localparam int NUM_PE = 8;
  localparam int AW     = 4;
  localparam int BW     = NUM_PE * 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          WR_VALID = 1'b0;
  logic          WR_READY;
  logic [AW-1:0] WR_ADDR = '0;
  logic [15:0]   WR_DATA = '0;
  logic          COMMIT = 1'b0;
  logic          ARRAY_BUSY = 1'b0;
  logic [BW-1:0] CONF_SE_ALL;
  logic          CONF_VALID;
  logic          PENDING;
  logic          ERR;
  logic          ERR_CLR = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] shadow_m = '0;
  logic [BW-1:0] active_m = '0;
  logic          pend_m   = 1'b0;
  logic          err_m    = 1'b0;
  logic [BW-1:0] sb_q[$];

  se_conf_loader #(.NUM_PE(NUM_PE), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .COMMIT(COMMIT), .ARRAY_BUSY(ARRAY_BUSY),
    .CONF_SE_ALL(CONF_SE_ALL), .CONF_VALID(CONF_VALID), .PENDING(PENDING),
    .ERR(ERR), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Independent legality rule; fields {N,S,E,W}, self codes N=1 S=3 E=2 W=4, codes above 7 undefined.
  function automatic logic word_legal(input logic [15:0] w);
`ifdef SE_CONF_CHECK_EN
    return (w[15:12] <= 4'd7) && (w[11:8] <= 4'd7) && (w[7:4] <= 4'd7) && (w[3:0] <= 4'd7) &&
           (w[15:12] != 4'd1) && (w[11:8] != 4'd3) && (w[7:4] != 4'd2) && (w[3:0] != 4'd4);
`else
    return (w == w);
`endif
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [15:0] d);
    if (int'(a) < NUM_PE && word_legal(d)) begin
      shadow_m[16*int'(a) +: 16] = d;
      pend_m = 1'b1;
    end else begin
      err_m = 1'b1;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d);
    WR_VALID = 1'b1;
    WR_ADDR  = a;
    WR_DATA  = d;
    step();
    WR_VALID = 1'b0;
    model_write(a, d);
    check("err_after_wr", ERR, err_m);
    check("pending_after_wr", PENDING, pend_m);
  endtask

  task automatic await_swap(input int exp_lat);
    int lat = 0;
    logic [BW-1:0] exp;
    while (!WR_READY && lat < 20) begin
      step();
      lat++;
    end
    check("swap_latency", lat, exp_lat);
    exp = sb_q.pop_front();
    check("conf_se_all", CONF_SE_ALL, exp);
    check("conf_valid", CONF_VALID, 1'b1);
    check("pending_cleared", PENDING, 1'b0);
    active_m = exp;
    pend_m   = 1'b0;
  endtask

  task automatic start_commit(input int busy_cycles);
    sb_q.push_back(shadow_m);
    ARRAY_BUSY = (busy_cycles > 0);
    COMMIT     = 1'b1;
    step();
    for (int i = 0; i < busy_cycles; i++) begin
      check("wait_ready_low", WR_READY, 1'b0);
      check("wait_conf_hold", CONF_SE_ALL, active_m);
      step();
    end
    COMMIT     = 1'b0;
    ARRAY_BUSY = 1'b0;
    check("commit_ready_low", WR_READY, 1'b0);
    check("commit_conf_hold", CONF_SE_ALL, active_m);
    await_swap((busy_cycles > 0) ? 2 : 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, WR_READY, 1'b1);
    check({tag, "_conf"}, CONF_SE_ALL, '0);
    check({tag, "_valid"}, CONF_VALID, 1'b0);
    check({tag, "_pending"}, PENDING, 1'b0);
    check({tag, "_err"}, ERR, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    step();
    step();
    RST = 1'b0;
    check_reset_state("reset");

    // Basic write/commit with idle array.
    do_write(4'd0, 16'h1234);
    do_write(4'd3, 16'h5678);
    start_commit(0);

    // Commit held off by a busy array.
    do_write(4'd1, 16'hAAAA);
    start_commit(5);

    // Out-of-range write, then a commit with nothing pending.
    do_write(4'd8, 16'hBEEF);
    COMMIT = 1'b1;
    step();
    COMMIT = 1'b0;
    check("idle_commit_ready", WR_READY, 1'b1);
    step();
    check("idle_commit_conf", CONF_SE_ALL, active_m);
    check("idle_commit_pending", PENDING, 1'b0);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    err_m = 1'b0;
    check("err_clr", ERR, err_m);

    // Error set beats a simultaneous clear.
    ERR_CLR = 1'b1;
    do_write(4'd9, 16'h0000);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    err_m = 1'b0;
    check("err_clr2", ERR, err_m);

    // Write and COMMIT in the same cycle.
    WR_VALID = 1'b1;
    WR_ADDR  = 4'd2;
    WR_DATA  = 16'h2560;
    COMMIT   = 1'b1;
    model_write(4'd2, 16'h2560);
    sb_q.push_back(shadow_m);
    step();
    WR_VALID = 1'b0;
    COMMIT   = 1'b0;
    check("same_cycle_ready", WR_READY, 1'b0);
    await_swap(1);

    // Last write wins, plus a few random in-range writes.
    do_write(4'd6, 16'h1111);
    do_write(4'd6, 16'h0777);
    for (int k = 0; k < 4; k++) begin
      do_write(AW'($urandom_range(0, NUM_PE - 1)), 16'($urandom));
    end
    start_commit(0);

    // Reset while waiting for the array: nothing may be copied.
    do_write(4'd5, 16'h3333);
    ARRAY_BUSY = 1'b1;
    COMMIT     = 1'b1;
    step();
    COMMIT = 1'b0;
    step();
    check("pre_rst_wait", WR_READY, 1'b0);
    RST = 1'b1;
    step();
    RST        = 1'b0;
    ARRAY_BUSY = 1'b0;
    shadow_m = '0;
    active_m = '0;
    pend_m   = 1'b0;
    err_m    = 1'b0;
    check_reset_state("mid_rst");
    step();
    step();
    step();
    check("post_rst_conf", CONF_SE_ALL, '0);
    check("post_rst_valid", CONF_VALID, 1'b0);

    // Self-loop and undefined code words, then a legal write to flush the bank.
    do_write(4'd4, 16'h1000);
    do_write(4'd6, 16'h000F);
    do_write(4'd7, 16'h0050);
    start_commit(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/se_conf_loader.md
Name: se_conf_loader

Overview:
- Configuration writer for the switch-element (SE) routing fabric. It is the producer side of the `CONF_SE` bus that each PE's SE consumes.
- Accepts configuration words from the host or config controller over a valid/ready handshake and stores them in a shadow bank.
- On COMMIT, and only when the array is idle, copies the whole shadow bank into the active bank that drives every PE's `CONF_SE` in parallel.
- Double buffering guarantees the SE muxes never see a partially written routing configuration.

Parameters:
- NUM_PE, 8, number of PEs/SEs served; one 16-bit `CONF_SE` word per PE.
- AW, 4, width of WR_ADDR; must satisfy 2^AW >= NUM_PE.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- WR_VALID  in  1  write request valid.
- WR_READY  out  1  loader can accept a write.
- WR_ADDR  in  AW  target PE index.
- WR_DATA  in  16  `CONF_SE` word, packed as {N,S,E,W}, 4 bits each, `CONF_SW_*` encodings.
- COMMIT  in  1  request shadow->active swap (level sampled in IDLE).
- ARRAY_BUSY  in  1  array is computing; a swap is forbidden while high.
- CONF_SE_ALL  out  NUM_PE*16  active config; PE i occupies bits [16i+15:16i].
- CONF_VALID  out  1  at least one commit has completed since reset.
- PENDING  out  1  shadow holds writes not yet committed.
- ERR  out  1  sticky error flag.
- ERR_CLR  in  1  clears ERR.

Behaviour:
- Reset values, applied at the RST edge, including mid-operation: state IDLE; shadow and active banks all 0; CONF_SE_ALL=0; CONF_VALID=0; PENDING=0; ERR=0. An in-progress WAIT_IDLE or SWAP is abandoned; nothing is copied.
- FSM states: IDLE, WAIT_IDLE, SWAP.
- IDLE: WR_READY=1.
  - A write is accepted when WR_VALID && WR_READY at a rising edge. It sets shadow[WR_ADDR] <= WR_DATA and PENDING <= 1.
  - WR_ADDR >= NUM_PE: data is dropped, ERR <= 1, PENDING unchanged.
  - Repeated writes to the same address: the last one wins.
- COMMIT in IDLE:
  - PENDING=0 (including a same-cycle write that is rejected): COMMIT is ignored and the state stays IDLE.
  - Otherwise: if ARRAY_BUSY=1, go to WAIT_IDLE; else go to SWAP.
  - A write accepted in the same cycle as COMMIT is included in that commit.
- WAIT_IDLE: WR_READY=0. Go to SWAP at the first edge where ARRAY_BUSY=0. COMMIT is ignored in this state.
- SWAP, one cycle: WR_READY=0. At the next edge:
  - active <= shadow (full bank copy);
  - CONF_VALID <= 1;
  - PENDING <= 0;
  - state returns to IDLE.
- Latency: with COMMIT and ARRAY_BUSY=0 sampled at edge T, CONF_SE_ALL shows the new value after edge T+1.
- CONF_SE_ALL is driven directly from registers; no combinational path from any input.
- Shadow contents persist after a swap, so incremental reconfiguration needs writes only to the changed PEs.
- ERR_CLR: ERR <= 0. If an error event occurs in the same cycle, the set wins.
- ARRAY_BUSY toggling during SWAP has no effect; the swap completes.

Optional Feature:
- Macro: SE_CONF_CHECK_EN.
- With the macro defined, each accepted write is checked. The write is rejected if any 4-bit field is an undefined code (> `CONF_SW_CONST_B`) or a self-loop:
  - N field = `CONF_SW_NORTH`;
  - S field = `CONF_SW_SOUTH`;
  - E field = `CONF_SW_EAST`;
  - W field = `CONF_SW_WEST`.
- A rejected write leaves the shadow unchanged and sets ERR <= 1; the handshake still completes (WR_READY=1).
- Without the macro, every in-range write is stored verbatim with no field checking.

Test Plan:
- Reset, then write PE0=16'h1234 and PE3=16'h5678 with ARRAY_BUSY=0, then COMMIT. Required: PENDING=1 after the first write; CONF_SE_ALL[15:0]=16'h1234 and [63:48]=16'h5678 one edge after SWAP; CONF_VALID=1; PENDING=0; other PEs remain 0.
- Write PE1=16'hAAAA and hold ARRAY_BUSY=1 while asserting COMMIT for 5 cycles. Required: WR_READY=0 and CONF_SE_ALL unchanged throughout. Then drop ARRAY_BUSY. Required: SWAP next cycle, and the PE1 slice = 16'hAAAA one edge later.
- Write to WR_ADDR=NUM_PE (8). Required: ERR=1, no shadow change, PENDING stays 0, and a following COMMIT is ignored. Then assert ERR_CLR. Required: ERR=0.
- Present a write to PE2 and COMMIT in the same cycle. Required: the commit includes PE2. Assert COMMIT with no pending writes. Required: no state change.
- Assert RST during WAIT_IDLE. Required: all outputs return to reset values and the active bank is 0, not the shadow contents.
- With SE_CONF_CHECK_EN defined, write a word whose N field = `CONF_SW_NORTH`, then a word with field value 4'hF. Required: both rejected, ERR=1, shadow unchanged. Without the macro, both words are stored.
